fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-request scheduler between the PC/branch-predictor front end, the instruction cache and the 8-entry instruction buffer. Generates the fetch PC stream and issues 1- or 2-instruction I-cache requests only when buffer credit covers every in-flight instruction. Tags and forwards in-order responses into the buffer write port, and discards responses made stale by a pipeline flush. Raises the fetch-address exception (ADEF) on a misaligned PC.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset
- BUF_DEPTH, 8, instruction buffer entries
- MAX_OUTSTANDING, 2, in-flight I-cache requests (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  redirect; discard all in-flight and buffered fetches
- flush_target  in  32  new fetch PC on flush
- bp_taken  in  2  per-slot predicted-taken for current req_pc (slot0 = req_pc, slot1 = req_pc+4)
- bp_target  in  32  predicted target for the first taken slot
- req_valid  out  1  I-cache request
- req_ready  in  1  I-cache accepts request
- req_pc  out  32  request address
- req_size  out  2  1 or 2 instructions
- resp_valid  in  1  in-order I-cache response
- resp_inst1, resp_inst2  in  32  returned instructions
- ibuf_consume  in  2  instructions popped from buffer this cycle
- ibuf_input_size  out  2  entries written to buffer this cycle
- ibuf_pc1/2, ibuf_inst1/2  out  32  write data
- ibuf_pred_taken1/2  out  1; ibuf_pred_target1/2  out  32
- have_exception  out  1  buffer-head exception flag (level)
- exception_type  out  exception_t  ADEF when have_exception, else don't-care

## Operation
- Registers: fetch_pc; tag FIFO (MAX_OUTSTANDING entries of pc, size, pred_taken[1:0], target; head/tail pointers plus count); drop counter; shadow occupancy occ (0..BUF_DEPTH).
- occ_next = occ + ibuf_input_size − ibuf_consume; occ is 4 bits. Flush forces occ to 0.
- Inflight instruction sum S = Σ size of the FIFO entries.
- Request size: 1 if fetch_pc[2]==1, or if bp_taken[0]; otherwise 2.
- Issue condition: state RUN, FIFO not full, drop==0, and occ + S + req_size ≤ BUF_DEPTH.
- On handshake (req_valid && req_ready): push a tag. fetch_pc ← bp_target if any bp_taken bit applies to an issued slot, else fetch_pc + 4·req_size (32-bit wrap).
- Pred outputs: pred_taken1 = bp_taken[0]; pred_taken2 = bp_taken[1] && size==2. Each pred_target = bp_target when taken, else pc+4.
- On resp_valid with drop==0: pop tag; ibuf_input_size = tag.size; pc1 = tag.pc, pc2 = tag.pc+4.
- On resp_valid with drop>0: drop−1; nothing is written.
- States:
  - RUN: normal issue. If fetch_pc[1:0]≠0 → EXC_DRAIN; no request is issued.
  - EXC_DRAIN: no issue. When the FIFO is empty, write one entry (pc = fetch_pc, inst = 32'h03400000) → EXC_HOLD.
  - EXC_HOLD: have_exception=1, exception_type=ADEF, no issue. Exits only on flush.
  - Any state + flush → RUN. fetch_pc ← flush_target; drop ← FIFO count (plus 1 if a handshake occurs in the same cycle, minus 1 if a live response arrives in the same cycle); FIFO cleared; ibuf_input_size forced to 0.
- Reset (asynchronous, any time, including mid-request): state RUN, fetch_pc=RESET_PC, FIFO/drop/occ=0. Outputs req_valid=0, ibuf_input_size=0, have_exception=0; all data outputs 0.

## Timing
- req_valid and req_pc are combinational from state, counters, fetch_pc and bp inputs. req_valid holds with a stable req_pc until req_ready.
- A response is forwarded to the buffer in the same cycle it arrives (zero latency); the buffer registers it.
- Minimum 1 cycle between a request handshake and its response; back-to-back handshakes are allowed every cycle while credit lasts.
- Flush in the same cycle as resp_valid: that response is dropped.
- Flush in the same cycle as a handshake: that request is counted in drop.
- While drop>0, no new request issues (bounds stale responses at MAX_OUTSTANDING).
- First request may issue in the first cycle after reset deasserts.

## Configuration
- FETCH_CTRL_BP_EN defined: bp_taken/bp_target are used as described.
- Undefined: bp inputs are ignored; treated as bp_taken=0. Size depends only on fetch_pc[2]; next PC is sequential; pred_taken outputs are 0; pred_target = pc+4.

## Test plan
- Reset release, req_ready=1, resp 1 cycle later, consume=0 → requests at 1c000000, 1c000008, 1c000010, 1c000018 (size 2 each); fifth request withheld (occ+S=8); one consume of 2 re-enables a request to 1c000020.
- flush_target=1c000104 → first request size 1 at 1c000104, then size 2 at 1c000108.
- Two requests outstanding, flush to 1c000200 → both later responses dropped (ibuf_input_size=0); next request at 1c000200 issues only after drop=0.
- Flush coincident with handshake and with a response → drop counts as specified; no stale instruction is written.
- flush_target=1c000002 → no request; after drain, one NOP entry pc=1c000002; have_exception=1, ADEF held until next flush.
- FETCH_CTRL_BP_EN defined, bp_taken=2'b01, bp_target=1c000400 at 1c000000 → size 1, pred_taken1=1, next request 1c000400; macro undefined → size 2, next request 1c000008.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Exception codes and the fetch controller's bus bundle (front end, I-cache, instruction buffer).
// The master modport is the fetch controller; the slave modport is its environment.
package fetch_ctrl_pkg;
    typedef enum logic [5:0] {
        EXC_NONE = 6'h00,
        ADEF     = 6'h08
    } exception_t;
endpackage

interface fetch_ctrl_if;
    logic                        flush;
    logic [31:0]                 flush_target;
    logic [1:0]                  bp_taken;
    logic [31:0]                 bp_target;
    logic                        req_valid;
    logic                        req_ready;
    logic [31:0]                 req_pc;
    logic [1:0]                  req_size;
    logic                        resp_valid;
    logic [31:0]                 resp_inst1;
    logic [31:0]                 resp_inst2;
    logic [1:0]                  ibuf_consume;
    logic [1:0]                  ibuf_input_size;
    logic [31:0]                 ibuf_pc1;
    logic [31:0]                 ibuf_pc2;
    logic [31:0]                 ibuf_inst1;
    logic [31:0]                 ibuf_inst2;
    logic                        ibuf_pred_taken1;
    logic                        ibuf_pred_taken2;
    logic [31:0]                 ibuf_pred_target1;
    logic [31:0]                 ibuf_pred_target2;
    logic                        have_exception;
    fetch_ctrl_pkg::exception_t  exception_type;

    modport master (
        input  flush, flush_target, bp_taken, bp_target, req_ready,
               resp_valid, resp_inst1, resp_inst2, ibuf_consume,
        output req_valid, req_pc, req_size, ibuf_input_size,
               ibuf_pc1, ibuf_pc2, ibuf_inst1, ibuf_inst2,
               ibuf_pred_taken1, ibuf_pred_taken2,
               ibuf_pred_target1, ibuf_pred_target2,
               have_exception, exception_type
    );

    modport slave (
        output flush, flush_target, bp_taken, bp_target, req_ready,
               resp_valid, resp_inst1, resp_inst2, ibuf_consume,
        input  req_valid, req_pc, req_size, ibuf_input_size,
               ibuf_pc1, ibuf_pc2, ibuf_inst1, ibuf_inst2,
               ibuf_pred_taken1, ibuf_pred_taken2,
               ibuf_pred_target1, ibuf_pred_target2,
               have_exception, exception_type
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Credit-based I-cache fetch scheduler with in-order tag FIFO, flush drop counter and ADEF handling.
// Define FETCH_CTRL_BP_EN to let bp_taken/bp_target steer request size and next PC.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          BUF_DEPTH       = 8,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    localparam int          PW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int          CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] EXC_NOP = 32'h03400000;

    typedef enum logic [1:0] {RUN, EXC_DRAIN, EXC_HOLD} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   tag_pc     [MAX_OUTSTANDING];
    logic [1:0]    tag_size   [MAX_OUTSTANDING];
    logic [1:0]    tag_taken  [MAX_OUTSTANDING];
    logic [31:0]   tag_target [MAX_OUTSTANDING];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] drop;
    logic [3:0]    occ;

    logic [1:0]    bp_taken_eff;
    logic [1:0]    size_sel;
    logic          pred1;
    logic          pred2;
    logic          take_branch;
    logic          fifo_full;
    logic [7:0]    inflight;
    logic [7:0]    credit_need;
    logic [PW-1:0] idx;
    logic          can_issue;
    logic          hs;
    logic          live;
    logic          resp_write;
    logic          exc_write;

`ifdef FETCH_CTRL_BP_EN
    assign bp_taken_eff = bus.bp_taken;
`else
    assign bp_taken_eff = 2'b00;
`endif

    assign size_sel    = (fetch_pc[2] || bp_taken_eff[0]) ? 2'd1 : 2'd2;
    assign pred1       = bp_taken_eff[0];
    assign pred2       = bp_taken_eff[1] && (size_sel == 2'd2);
    assign take_branch = pred1 || pred2;
    assign fifo_full   = (count == CW'(MAX_OUTSTANDING));

    always_comb begin
        inflight = '0;
        idx      = '0;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            idx = head + PW'(i);
            if (i < int'(count))
                inflight = inflight + {6'd0, tag_size[idx]};
        end
    end

    // Credit covers buffered entries, every in-flight instruction and this request.
    assign credit_need = {4'd0, occ} + inflight + {6'd0, size_sel};
    assign can_issue   = reset && (state == RUN) && (fetch_pc[1:0] == 2'b00) && !fifo_full
                         && (drop == '0) && (credit_need <= 8'(BUF_DEPTH));
    assign hs          = can_issue && bus.req_ready;
    assign live        = reset && bus.resp_valid && (drop == '0) && (count != '0);
    assign resp_write  = live && !bus.flush;
    assign exc_write   = reset && (state == EXC_DRAIN) && (count == '0)
                         && (occ < 4'(BUF_DEPTH)) && !bus.flush;

    always_comb begin
        bus.req_valid         = can_issue;
        bus.req_pc            = can_issue ? fetch_pc : '0;
        bus.req_size          = can_issue ? size_sel : '0;
        bus.ibuf_input_size   = '0;
        bus.ibuf_pc1          = '0;
        bus.ibuf_pc2          = '0;
        bus.ibuf_inst1        = '0;
        bus.ibuf_inst2        = '0;
        bus.ibuf_pred_taken1  = 1'b0;
        bus.ibuf_pred_taken2  = 1'b0;
        bus.ibuf_pred_target1 = '0;
        bus.ibuf_pred_target2 = '0;
        if (resp_write) begin
            bus.ibuf_input_size   = tag_size[head];
            bus.ibuf_pc1          = tag_pc[head];
            bus.ibuf_pc2          = tag_pc[head] + 32'd4;
            bus.ibuf_inst1        = bus.resp_inst1;
            bus.ibuf_inst2        = bus.resp_inst2;
            bus.ibuf_pred_taken1  = tag_taken[head][0];
            bus.ibuf_pred_taken2  = tag_taken[head][1];
            bus.ibuf_pred_target1 = tag_taken[head][0] ? tag_target[head] : tag_pc[head] + 32'd4;
            bus.ibuf_pred_target2 = tag_taken[head][1] ? tag_target[head] : tag_pc[head] + 32'd8;
        end else if (exc_write) begin
            bus.ibuf_input_size   = 2'd1;
            bus.ibuf_pc1          = fetch_pc;
            bus.ibuf_pc2          = fetch_pc + 32'd4;
            bus.ibuf_inst1        = EXC_NOP;
            bus.ibuf_pred_target1 = fetch_pc + 32'd4;
            bus.ibuf_pred_target2 = fetch_pc + 32'd8;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= RUN;
            fetch_pc           <= RESET_PC;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            drop               <= '0;
            occ                <= '0;
            bus.have_exception <= 1'b0;
            bus.exception_type <= fetch_ctrl_pkg::EXC_NONE;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_pc[i]     <= '0;
                tag_size[i]   <= '0;
                tag_taken[i]  <= '0;
                tag_target[i] <= '0;
            end
        end else begin
            occ   <= occ + {2'b00, bus.ibuf_input_size} - {2'b00, bus.ibuf_consume};
            count <= count + CW'(hs) - CW'(live);
            if (hs) begin
                tag_pc[tail]     <= fetch_pc;
                tag_size[tail]   <= size_sel;
                tag_taken[tail]  <= {pred2, pred1};
                tag_target[tail] <= bus.bp_target;
                tail             <= tail + 1'b1;
                fetch_pc         <= take_branch ? bus.bp_target
                                                : fetch_pc + {28'd0, size_sel, 2'b00};
            end
            if (live)
                head <= head + 1'b1;
            if ((drop != '0) && bus.resp_valid)
                drop <= drop - 1'b1;
            case (state)
                RUN: begin
                    if (fetch_pc[1:0] != 2'b00)
                        state <= EXC_DRAIN;
                end
                EXC_DRAIN: begin
                    if (exc_write) begin
                        state              <= EXC_HOLD;
                        bus.have_exception <= 1'b1;
                        bus.exception_type <= fetch_ctrl_pkg::ADEF;
                    end
                end
                default: ;
            endcase
            // Stale count keeps any still-pending drops, adds this cycle's issue, removes this cycle's live pop.
            if (bus.flush) begin
                state              <= RUN;
                fetch_pc           <= bus.flush_target;
                head               <= '0;
                tail               <= '0;
                count              <= '0;
                occ                <= '0;
                bus.have_exception <= 1'b0;
                bus.exception_type <= fetch_ctrl_pkg::EXC_NONE;
                drop <= drop - CW'((drop != '0) && bus.resp_valid) + count + CW'(hs) - CW'(live);
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed per-cycle vector table for fetch_ctrl plus hand-written reset sequences.
module tb_fetch_ctrl;
    localparam logic [31:0] RI  = 32'h00112233;
    localparam logic [31:0] NOP = 32'h03400000;
`ifdef FETCH_CTRL_BP_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    typedef struct {
        logic        flush;
        logic [31:0] ftgt;
        logic        ready;
        logic        resp;
        logic [1:0]  consume;
        logic [1:0]  bpt;
        logic [31:0] bptgt;
        logic        rv;
        logic [31:0] rpc;
        logic [1:0]  rsz;
        logic [1:0]  isz;
        logic [31:0] ipc1;
        logic [31:0] iinst1;
        logic        pt1;
        logic        exc;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    vec_t vecs[$];

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic f, input logic [31:0] ft, input logic rdy,
                                input logic rsp, input logic [1:0] cons, input logic [1:0] bpt,
                                input logic [31:0] bptgt, input logic rv, input logic [31:0] rpc,
                                input logic [1:0] rsz, input logic [1:0] isz,
                                input logic [31:0] ipc1, input logic [31:0] iinst1,
                                input logic pt1, input logic exc);
        vec_t v;
        v.flush = f;    v.ftgt = ft;     v.ready = rdy;  v.resp = rsp;
        v.consume = cons; v.bpt = bpt;   v.bptgt = bptgt;
        v.rv = rv;      v.rpc = rpc;     v.rsz = rsz;    v.isz = isz;
        v.ipc1 = ipc1;  v.iinst1 = iinst1; v.pt1 = pt1;  v.exc = exc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.flush        = v.flush;
        bus.flush_target = v.ftgt;
        bus.req_ready    = v.ready;
        bus.resp_valid   = v.resp;
        bus.ibuf_consume = v.consume;
        bus.bp_taken     = v.bpt;
        bus.bp_target    = v.bptgt;
    endtask

    task automatic check_output(input vec_t v, input int n);
        check($sformatf("v%0d req_valid", n), 32'(bus.req_valid), 32'(v.rv));
        if (v.rv) begin
            check($sformatf("v%0d req_pc", n), bus.req_pc, v.rpc);
            check($sformatf("v%0d req_size", n), 32'(bus.req_size), 32'(v.rsz));
        end
        check($sformatf("v%0d input_size", n), 32'(bus.ibuf_input_size), 32'(v.isz));
        if (v.isz != 2'd0) begin
            check($sformatf("v%0d ibuf_pc1", n), bus.ibuf_pc1, v.ipc1);
            check($sformatf("v%0d ibuf_inst1", n), bus.ibuf_inst1, v.iinst1);
            check($sformatf("v%0d pred_taken1", n), 32'(bus.ibuf_pred_taken1), 32'(v.pt1));
        end
        check($sformatf("v%0d have_exception", n), 32'(bus.have_exception), 32'(v.exc));
        if (v.exc)
            check($sformatf("v%0d exception_type", n), 32'(bus.exception_type),
                  32'(fetch_ctrl_pkg::ADEF));
    endtask

    initial begin
        // Fill order: flush, ftgt, ready, resp, consume, bpt, bptgt | rv, rpc, rsz, isz, ipc1, inst1, pt1, exc
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000000, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 32'h1c000008, 2, 2, 32'h1c000000, RI, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 32'h1c000010, 2, 2, 32'h1c000008, RI, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 32'h1c000018, 2, 2, 32'h1c000010, RI, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 32'h1c000018, RI, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000020, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 32'h1c000020, RI, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 1, 32'h1c000028, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 1, 32'h1c000028, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 1, 32'h1c000028, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h1c000028, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000104, 0, 0, 0, 0, 0, 1, 32'h1c000028, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000104, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 32'h1c000108, 2, 1, 32'h1c000104, RI, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h1c000110, 2, 2, 32'h1c000108, RI, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000110, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000118, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000200, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000300, 1, 1, 0, 0, 0, 1, 32'h1c000208, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 32'h1c000300, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h1c000308, 2, 2, 32'h1c000300, RI, 0, 0));
        vecs.push_back(mk(1, 32'h1c000002, 0, 0, 0, 0, 0, 1, 32'h1c000308, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1c000002, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h1c000500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h1c000500, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1c000000, 0, 0, 0, 0, 0, 1, 32'h1c000500, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2'b01, 32'h1c000400, 1, 32'h1c000000,
                          BP ? 2'd1 : 2'd2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, BP ? 32'h1c000400 : 32'h1c000008, 2,
                          BP ? 2'd1 : 2'd2, 32'h1c000000, RI, BP, 0));

        bus.flush        = 1'b0;
        bus.flush_target = '0;
        bus.bp_taken     = '0;
        bus.bp_target    = '0;
        bus.req_ready    = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_inst1   = RI;
        bus.resp_inst2   = 32'h44556677;
        bus.ibuf_consume = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_valid", 32'(bus.req_valid), 32'd0);
        check("reset input_size", 32'(bus.ibuf_input_size), 32'd0);
        check("reset have_exception", 32'(bus.have_exception), 32'd0);
        check("reset ibuf_pc1", bus.ibuf_pc1, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output(vecs[i], i + 1);
        end

        // Asynchronous reset while a request is pending, then restart at RESET_PC.
        @(posedge clk);
        #1;
        bus.resp_valid = 1'b0;
        bus.req_ready  = 1'b0;
        bus.bp_taken   = '0;
        #2;
        reset = 1'b0;
        #1;
        check("midreset req_valid", 32'(bus.req_valid), 32'd0);
        check("midreset req_pc", bus.req_pc, 32'd0);
        check("midreset input_size", 32'(bus.ibuf_input_size), 32'd0);
        check("midreset have_exception", 32'(bus.have_exception), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("restart req_valid", 32'(bus.req_valid), 32'd1);
        check("restart req_pc", bus.req_pc, 32'h1c000000);
        check("restart req_size", 32'(bus.req_size), 32'd2);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
